// File: rtl/sad_search_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : sad_search_ctrl_if
// Purpose  : Host start/status, buffer row fetch and SAD kernel control bundle.
//            Optional SAD_EARLY_TERM_EN adds the early_terms counter.
// Revision : 1.0 - initial release
// =============================================================================
interface sad_search_ctrl_if #(
  parameter int XW = 4,
  parameter int YW = 4,
  parameter int RW = 5
);
  logic          start;
  logic          busy;
  logic          done;
  logic          row_req;
  logic [RW-1:0] row_idx;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          row_gnt;
  logic          sad_active;
  logic          sad_valid;
  logic          sad_done;
  logic [31:0]   sad_in;
  logic [31:0]   best_sad;
  logic [XW-1:0] best_x;
  logic [YW-1:0] best_y;
`ifdef SAD_EARLY_TERM_EN
  logic [15:0]   early_terms;
`endif

  modport master (
    input  start, row_gnt, sad_in,
    output busy, done, row_req, row_idx, pos_x, pos_y,
           sad_active, sad_valid, sad_done, best_sad, best_x, best_y
`ifdef SAD_EARLY_TERM_EN
    , output early_terms
`endif
  );

  modport slave (
    output start, row_gnt, sad_in,
    input  busy, done, row_req, row_idx, pos_x, pos_y,
           sad_active, sad_valid, sad_done, best_sad, best_x, best_y
`ifdef SAD_EARLY_TERM_EN
    , input early_terms
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sad_search_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : sad_search_ctrl
// Purpose  : Raster search over candidate positions, driving one SAD kernel and
//            tracking the minimum SAD. Optional macro: SAD_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// =============================================================================
module sad_search_ctrl #(
  parameter int ROWS     = 32,
  parameter int POS_X    = 16,
  parameter int POS_Y    = 16,
  parameter int PIPE_LAT = 2,
  parameter int XW       = 4,
  parameter int YW       = 4,
  parameter int RW       = 5
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sad_search_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [31:0]   SAD_INIT = 32'hFFFF_FFFF;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(POS_X - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(POS_Y - 1);

  logic [2:0]          state_q, state_d;
  logic [RW-1:0]       row_idx_q, row_idx_d;
  logic [XW-1:0]       pos_x_q, pos_x_d, best_x_q, best_x_d;
  logic [YW-1:0]       pos_y_q, pos_y_d, best_y_q, best_y_d;
  logic [31:0]         best_sad_q, best_sad_d;
  logic [PIPE_LAT-1:0] vsr_q, vsr_d, vsr_shift;
  logic                gnt_acc, last_row, last_pos, abort;

  assign gnt_acc   = (state_q == S_FETCH) && bus.row_gnt;
  assign last_row  = (row_idx_q == LAST_ROW);
  assign last_pos  = (pos_x_q == LAST_X) && (pos_y_q == LAST_Y);
  // Mirrors the kernel pipeline: a grant becomes an accumulate PIPE_LAT cycles later.
  assign vsr_shift = PIPE_LAT'({vsr_q, gnt_acc});

`ifdef SAD_EARLY_TERM_EN
  logic [15:0] early_terms_q, early_terms_d;

  // A partial sum already at or above the best cannot win under strict less-than.
  assign abort = ((state_q == S_FETCH) || (state_q == S_DRAIN)) &&
                 (best_sad_q != SAD_INIT) && (bus.sad_in >= best_sad_q);

  always_comb begin
    early_terms_d = early_terms_q;
    if ((state_q == S_IDLE) && bus.start) begin
      early_terms_d = '0;
    end else if (abort) begin
      early_terms_d = early_terms_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_terms_q <= '0;
    end else begin
      early_terms_q <= early_terms_d;
    end
  end

  assign bus.early_terms = early_terms_q;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_idx_q  <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      best_sad_q <= SAD_INIT;
      best_x_q   <= '0;
      best_y_q   <= '0;
      vsr_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      vsr_q      <= vsr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    vsr_d      = vsr_shift;
    case (state_q)
      S_IDLE: begin
        vsr_d = '0;
        if (bus.start) begin
          state_d    = S_FETCH;
          row_idx_d  = '0;
          pos_x_d    = '0;
          pos_y_d    = '0;
          best_sad_d = SAD_INIT;
          best_x_d   = '0;
          best_y_d   = '0;
        end
      end
      S_FETCH: begin
        if (gnt_acc) begin
          if (last_row) begin
            state_d = S_DRAIN;
          end else begin
            row_idx_d = row_idx_q + RW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (vsr_shift == '0) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_CLEAR;
        // Strict compare: on a tie the earlier raster position is kept.
        if (bus.sad_in < best_sad_q) begin
          best_sad_d = bus.sad_in;
          best_x_d   = pos_x_q;
          best_y_d   = pos_y_q;
        end
      end
      S_CLEAR: begin
        vsr_d     = '0;
        row_idx_d = '0;
        if (last_pos) begin
          state_d = S_DONE;
          pos_x_d = '0;
          pos_y_d = '0;
        end else begin
          state_d = S_FETCH;
          if (pos_x_q == LAST_X) begin
            pos_x_d = '0;
            pos_y_d = pos_y_q + YW'(1);
          end else begin
            pos_x_d = pos_x_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        vsr_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        vsr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_CLEAR;
      vsr_d   = '0;
    end
  end

  always_comb begin
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.row_req    = 1'b0;
    bus.sad_active = 1'b0;
    bus.sad_done   = 1'b0;
    case (state_q)
      S_IDLE:    bus.busy = 1'b0;
      S_FETCH: begin
        bus.row_req    = 1'b1;
        bus.sad_active = 1'b1;
      end
      S_DRAIN:   bus.sad_active = 1'b1;
      S_CAPTURE: begin
        bus.sad_active = 1'b1;
        bus.sad_done   = 1'b1;
      end
      S_DONE:    bus.done = 1'b1;
      default:   ;
    endcase
  end

  assign bus.sad_valid = vsr_q[PIPE_LAT-1] & bus.sad_active;
  assign bus.row_idx   = row_idx_q;
  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_x    = best_x_q;
  assign bus.best_y    = best_y_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_search_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_sad_search_ctrl
// Purpose  : Directed scenarios on a 2x2 window of 4-row blocks with a
//            behavioural SAD kernel. Build with SAD_EARLY_TERM_EN for that test.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sad_search_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [31:0] rv [0:3][0:3];
  logic [31:0] acc = '0;
  logic [31:0] pipe_q [$];
  int          gcount [0:3];
  int          vmis, vcnt, runs, badruns, lolen;
  logic        g1 = 1'b0;
  logic        g2 = 1'b0;

  sad_search_ctrl_if #(.XW(1), .YW(1), .RW(2)) bus ();

  sad_search_ctrl #(
    .ROWS(4), .POS_X(2), .POS_Y(2), .PIPE_LAT(2), .XW(1), .YW(1), .RW(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.sad_in = acc;

  // Kernel model: a granted row's SAD enters a queue and is summed on sad_valid.
  always @(posedge clk) begin : kernel_model
    int cand;
    cand = int'({bus.pos_y, bus.pos_x});
    if (bus.start && !bus.busy) for (int i = 0; i < 4; i++) gcount[i] = 0;
    if (!bus.sad_active) begin
      acc <= '0;
      pipe_q.delete();
    end else begin
      if (bus.sad_valid && !bus.sad_done && pipe_q.size() > 0) acc <= acc + pipe_q.pop_front();
      if (bus.row_req && bus.row_gnt) begin
        pipe_q.push_back(rv[cand][bus.row_idx]);
        gcount[cand]++;
      end
    end
  end

  always @(negedge clk) begin : valid_monitor
    if (bus.start && !bus.busy) begin
      vmis = 0; vcnt = 0; runs = 0; badruns = 0; lolen = 0; g1 = 1'b0; g2 = 1'b0;
    end else begin
      if (bus.sad_valid !== g2) vmis++;
      if (bus.sad_valid) vcnt++;
      g2 = g1;
      g1 = bus.row_req & bus.row_gnt;
      if (bus.busy && !bus.sad_active) lolen++;
      else if (bus.busy && lolen > 0) begin
        runs++;
        if (lolen != 1) badruns++;
        lolen = 0;
      end
    end
  end

  task automatic set_cand(input int c, input logic [31:0] a, b, d, e);
    rv[c][0] = a; rv[c][1] = b; rv[c][2] = d; rv[c][3] = e;
  endtask

  task automatic set_default();
    set_cand(0, 10, 10, 10, 10);
    set_cand(1,  5, 10,  5, 10);
    set_cand(2,  0,  0,  0, 30);
    set_cand(3,  5,  5,  5, 35);
  endtask

  // mode 0: gnt tied high, 1: random, 2: alternating
  task automatic run_search(input int mode, input int restart_at, input int tail,
                            output int lat, output int ndone, output bit early_low,
                            output bit busy_after);
    bit seen;
    lat = -1; ndone = 0; early_low = 1'b0; busy_after = 1'b1; seen = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(posedge clk); #2;
      bus.start = (cyc == restart_at);
      case (mode)
        0:       bus.row_gnt = 1'b1;
        1:       bus.row_gnt = 1'($urandom_range(0, 1));
        default: bus.row_gnt = cyc[0];
      endcase
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (!seen) begin seen = 1'b1; lat = cyc; end
      end else if (!seen && !bus.busy) early_low = 1'b1;
      if (seen && cyc == lat + 1) busy_after = bus.busy;
      if (seen && cyc >= lat + tail) break;
    end
    bus.start = 1'b0;
    bus.row_gnt = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst_n = 1'b0; bus.start = 1'b0; bus.row_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.busy, bus.done, bus.row_req, bus.sad_active, bus.sad_valid, bus.sad_done,
           bus.row_idx, bus.pos_x, bus.pos_y, bus.best_x, bus.best_y};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL reset_outputs: got %b expected 0", obs); else n_pass++;
    n_checks++;
    if (bus.best_sad !== 32'hFFFF_FFFF) $display("FAIL reset_best_sad: got %h expected ffffffff", bus.best_sad); else n_pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bus.busy, bus.done, bus.row_req, bus.sad_active, bus.sad_valid, bus.sad_done,
           bus.row_idx, bus.pos_x, bus.pos_y, bus.best_x, bus.best_y};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL idle_outputs: got %b expected 0", obs); else n_pass++;
  endtask

  task automatic test_basic();
    int lat, nd; bit el, ba;
    set_default();
    run_search(0, 0, 3, lat, nd, el, ba);
    n_checks++; if (lat !== 33) $display("FAIL basic_latency: got %0d expected 33", lat); else n_pass++;
    n_checks++; if (bus.best_sad !== 32'd30) $display("FAIL basic_best_sad: got %0d expected 30", bus.best_sad); else n_pass++;
    n_checks++; if (bus.best_x !== 1'b1) $display("FAIL basic_best_x: got %0d expected 1", bus.best_x); else n_pass++;
    n_checks++; if (bus.best_y !== 1'b0) $display("FAIL basic_best_y: got %0d expected 0", bus.best_y); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL basic_done_count: got %0d expected 1", nd); else n_pass++;
    n_checks++; if (ba !== 1'b0) $display("FAIL basic_busy_after_done: got %0d expected 0", ba); else n_pass++;
    n_checks++; if (vmis !== 0) $display("FAIL basic_valid_align: got %0d misaligned expected 0", vmis); else n_pass++;
    n_checks++; if (vcnt !== 16) $display("FAIL basic_valid_count: got %0d expected 16", vcnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (gcount[i] !== 4) $display("FAIL basic_grants_c%0d: got %0d expected 4", i, gcount[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int lat, nd; bit el, ba;
    set_default();
    run_search(1, 0, 3, lat, nd, el, ba);
    n_checks++; if (nd !== 1) $display("FAIL stall_done_count: got %0d expected 1", nd); else n_pass++;
    n_checks++; if (bus.best_sad !== 32'd30) $display("FAIL stall_best_sad: got %0d expected 30", bus.best_sad); else n_pass++;
    n_checks++; if ({bus.best_y, bus.best_x} !== 2'b01) $display("FAIL stall_best_pos: got y%0d x%0d expected y0 x1", bus.best_y, bus.best_x); else n_pass++;
    n_checks++; if (vmis !== 0) $display("FAIL stall_valid_align: got %0d misaligned expected 0", vmis); else n_pass++;
    n_checks++; if (vcnt !== 16) $display("FAIL stall_valid_count: got %0d expected 16", vcnt); else n_pass++;
  endtask

  task automatic test_start_busy();
    int lat, nd; bit el, ba;
    set_default();
    run_search(0, 10, 40, lat, nd, el, ba);
    n_checks++; if (nd !== 1) $display("FAIL busy_start_done_count: got %0d expected 1", nd); else n_pass++;
    n_checks++; if (el !== 1'b0) $display("FAIL busy_start_busy_dropped: got %0d expected 0", el); else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL busy_start_latency: got %0d expected 33", lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] obs;
    bit found;
    int nd, lat; bit el, ba;
    set_default();
    found = 1'b0; nd = 0;
    @(posedge clk); #2;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #2;
      bus.start = 1'b0;
      bus.row_gnt = 1'b1;
      @(negedge clk);
      if (bus.pos_x == 1'b1 && bus.row_req) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rstmid_reach_cand2: got %0d expected 1", found); else n_pass++;
    rst_n = 1'b0;
    #1;
    obs = {bus.busy, bus.done, bus.row_req, bus.sad_active, bus.sad_valid, bus.sad_done,
           bus.row_idx, bus.pos_x, bus.pos_y, bus.best_x, bus.best_y};
    n_checks++; if (obs !== 12'd0) $display("FAIL rstmid_outputs: got %b expected 0", obs); else n_pass++;
    n_checks++; if (bus.best_sad !== 32'hFFFF_FFFF) $display("FAIL rstmid_best_sad: got %h expected ffffffff", bus.best_sad); else n_pass++;
    @(posedge clk); #2;
    bus.row_gnt = 1'b0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    n_checks++; if (nd !== 0) $display("FAIL rstmid_no_done: got %0d busy/done cycles expected 0", nd); else n_pass++;
    run_search(0, 0, 3, lat, nd, el, ba);
    n_checks++; if (lat !== 33) $display("FAIL rstmid_restart_latency: got %0d expected 33", lat); else n_pass++;
    n_checks++; if (bus.best_sad !== 32'd30) $display("FAIL rstmid_restart_best: got %0d expected 30", bus.best_sad); else n_pass++;
  endtask

  task automatic test_equal();
    int lat, nd; bit el, ba;
    for (int c = 0; c < 4; c++) set_cand(c, 0, 0, 0, 0);
    run_search(0, 0, 3, lat, nd, el, ba);
    n_checks++; if (bus.best_sad !== 32'd0) $display("FAIL equal_best_sad: got %0d expected 0", bus.best_sad); else n_pass++;
    n_checks++; if ({bus.best_y, bus.best_x} !== 2'b00) $display("FAIL equal_best_pos: got y%0d x%0d expected y0 x0", bus.best_y, bus.best_x); else n_pass++;
    n_checks++; if (runs !== 3) $display("FAIL equal_inactive_gaps: got %0d expected 3", runs); else n_pass++;
    n_checks++; if (badruns !== 0) $display("FAIL equal_gap_length: got %0d gaps not 1 cycle expected 0", badruns); else n_pass++;
  endtask

`ifdef SAD_EARLY_TERM_EN
  task automatic test_early_term();
    int lat, nd; bit el, ba;
    set_cand(0,   1,   2,  3,  4);
    set_cand(1,  50,  50, 50, 50);
    set_cand(2,   1,   1,  1,  2);
    set_cand(3, 100, 100, 50, 50);
    run_search(2, 0, 3, lat, nd, el, ba);
    n_checks++; if (lat <= 0) $display("FAIL early_done_seen: got %0d expected positive latency", lat); else n_pass++;
    n_checks++; if (bus.early_terms !== 16'd2) $display("FAIL early_terms: got %0d expected 2", bus.early_terms); else n_pass++;
    n_checks++; if (bus.best_sad !== 32'd5) $display("FAIL early_best_sad: got %0d expected 5", bus.best_sad); else n_pass++;
    n_checks++; if ({bus.best_y, bus.best_x} !== 2'b10) $display("FAIL early_best_pos: got y%0d x%0d expected y1 x0", bus.best_y, bus.best_x); else n_pass++;
    n_checks++; if (gcount[1] >= 4) $display("FAIL early_grants_c1: got %0d expected <4", gcount[1]); else n_pass++;
    n_checks++; if (gcount[3] >= 4) $display("FAIL early_grants_c3: got %0d expected <4", gcount[3]); else n_pass++;
    n_checks++; if (gcount[2] !== 4) $display("FAIL early_grants_c2: got %0d expected 4", gcount[2]); else n_pass++;
  endtask
`endif

  initial begin
    bus.start   = 1'b0;
    bus.row_gnt = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_equal();
`ifdef SAD_EARLY_TERM_EN
    test_early_term();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequences one compute_sad_kernel instance across a raster of candidate positions in a search window.
- For each candidate:
  - requests ROWS row-pairs (face/group, 256 bits each) from the block buffer;
  - aligns the kernel's sad_valid to its 2-stage pipeline;
  - closes the accumulation and reads back the SAD;
  - clears the kernel before the next candidate.
- Tracks the minimum SAD and its (x,y) position, and reports it on completion.
- Sits between the host/DMA control registers and the kernel/buffer pair.

Parameters:
ROWS, 32, rows of 32 pixels per block (rows fetched per candidate)
POS_X, 16, candidate columns in search window
POS_Y, 16, candidate rows in search window
PIPE_LAT, 2, kernel cycles from face/group input to sad accumulation
XW, 4, width of pos_x/best_x (clog2(POS_X))
YW, 4, width of pos_y/best_y (clog2(POS_Y))
RW, 5, width of row_idx (clog2(ROWS))

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a search; ignored while busy
busy  out  1  high from cycle after accepted start until done pulse
done  out  1  one-cycle pulse when search complete
row_req  out  1  row fetch request
row_idx  out  RW  row within block for current request
pos_x  out  XW  current candidate column
pos_y  out  YW  current candidate row
row_gnt  in  1  buffer drives face/group to kernel in this cycle; completes request
sad_active  out  1  kernel enable; low clears kernel
sad_valid  out  1  kernel accumulate strobe
sad_done  out  1  kernel hold strobe
sad_in  in  32  kernel sad output
best_sad  out  32  minimum SAD found
best_x  out  XW  column of minimum
best_y  out  YW  row of minimum

Behaviour:
- Reset values: all outputs 0; best_sad = 32'hFFFF_FFFF; state IDLE.
- Async reset mid-search aborts immediately. No done pulse follows. best_* return to reset values.
- States:
  - IDLE: sad_active=0. On start: pos=(0,0), row_idx=0, best_sad=FFFF_FFFF, best_x/best_y=0, go to FETCH.
  - FETCH: sad_active=1, row_req=1. row_idx/pos stable until row_gnt.
    - On row_gnt with row_idx<ROWS-1: row_idx++.
    - On row_gnt with row_idx=ROWS-1: row_req drops next cycle, go to DRAIN.
    - row_gnt may stall arbitrarily; gaps are legal.
  - DRAIN: wait until the valid shift register is empty, i.e. PIPE_LAT cycles after the last gnt, then go to CAPTURE.
  - CAPTURE (1 cycle): sad_done=1. If sad_in < best_sad (strict; ties keep the earlier raster position), load best_sad/best_x/best_y. Go to CLEAR.
  - CLEAR (1 cycle): sad_active=0. Advance pos raster-order: x++; at x=POS_X-1 wrap x=0 and y++. If the last candidate was just captured, go to DONE; else row_idx=0 and go to FETCH.
  - DONE (1 cycle): done=1, busy=0 next cycle, go to IDLE. best_* hold until next accepted start.
- sad_valid: row_gnt delayed through a PIPE_LAT-deep shift register, gated by sad_active. The shift register is cleared in CLEAR/IDLE.
- Per-candidate latency with no stalls: ROWS + PIPE_LAT + 2 cycles. Full search: POS_X*POS_Y of these, plus 1 (DONE).
- row_gnt without row_req: ignored.
- start during busy: ignored.

Optional Feature:
- Macro SAD_EARLY_TERM_EN.
- Defined:
  - In FETCH or DRAIN, if best_sad != FFFF_FFFF and sad_in >= best_sad, the candidate is abandoned.
  - row_req drops next cycle; the valid shift register is flushed; state goes to CLEAR, skipping CAPTURE.
  - Add output early_terms (16 bits): count of abandoned candidates, cleared on start.
- Undefined: every candidate fetches all ROWS; early_terms is absent.

Test Plan:
(Bench params: ROWS=4, POS_X=2, POS_Y=2, PIPE_LAT=2.)
1. Single search, row_gnt tied high, per-candidate SADs 40,30,30,50 -> best_sad=30, best_x=1, best_y=0 (tie keeps first); done exactly 4*8+1=33 cycles after start accepted.
2. Random row_gnt stalls (50% duty) -> sad_valid pulses exactly 4 per candidate, each 2 cycles after a gnt; results identical to scenario 1.
3. start pulsed while busy at cycle 10 -> ignored; single done pulse; busy low only after done.
4. rst_n asserted during second candidate's FETCH -> next cycle: all outputs reset values, best_sad=FFFF_FFFF; no done pulse; a new start then completes normally.
5. All candidates equal (SAD=0) -> best_sad=0, best_x=0, best_y=0; sad_active low exactly one cycle between candidates.
6. SAD_EARLY_TERM_EN defined, candidate SADs 10,200,5,300 with first row contributing >10 for candidates 1 and 3 -> early_terms=2, best_sad=5, best_x=0, best_y=1; abandoned candidates issue fewer than 4 row_req grants.
